// File: rtl/hct_counter_n_if.sv
// rtl/hct_counter_n_if.sv - control/data bundle for hct_counter_n.
// CMP/MATCH exist only when HCT_COUNTER_MATCH_EN is defined.
interface hct_counter_n_if #(
   parameter int WIDTH = 4
);
   logic             _SR;
   logic             _PE;
   logic             CEP;
   logic             CET;
   logic             UP;
   logic [WIDTH-1:0] LIMIT;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             TC;
`ifdef HCT_COUNTER_MATCH_EN
   logic [WIDTH-1:0] CMP;
   logic             MATCH;
`endif

`ifdef HCT_COUNTER_MATCH_EN
   modport master (output _SR, _PE, CEP, CET, UP, LIMIT, D, CMP, input Q, TC, MATCH);
   modport slave  (input _SR, _PE, CEP, CET, UP, LIMIT, D, CMP, output Q, TC, MATCH);
`else
   modport master (output _SR, _PE, CEP, CET, UP, LIMIT, D, input Q, TC);
   modport slave  (input _SR, _PE, CEP, CET, UP, LIMIT, D, output Q, TC);
`endif
endinterface

// File: rtl/hct_counter_n.sv
// rtl/hct_counter_n.sv - loadable up/down counter with programmable terminal value and cascade enables.
// Optional registered compare output under HCT_COUNTER_MATCH_EN.
module hct_counter_n #(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0
) (
   input logic            CP,
   input logic            MR,
   hct_counter_n_if.slave bus
);
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next;
   logic             at_limit;
   logic             at_zero;
   logic             count_en;

   assign at_limit = (q_r == bus.LIMIT);
   assign at_zero  = (q_r == '0);
   assign count_en = bus.CEP & bus.CET;

   always_comb begin
      q_next = q_r;
      if (!bus._SR) begin
         q_next = '0;
      end else if (!bus._PE) begin
         q_next = bus.D;
      end else if (count_en) begin
         if (bus.UP) begin
            // A value above LIMIT never equals it, so it runs on and wraps through all-ones.
            if (at_limit)
               q_next = (SATURATE != 0) ? q_r : '0;
            else
               q_next = q_r + WIDTH'(1);
         end else begin
            if (at_zero)
               q_next = (SATURATE != 0) ? q_r : bus.LIMIT;
            else
               q_next = q_r - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR)
         q_r <= '0;
      else
         q_r <= q_next;
   end

   assign bus.Q  = q_r;
   assign bus.TC = bus.CET & (bus.UP ? at_limit : at_zero);

`ifdef HCT_COUNTER_MATCH_EN
   logic match_r;

   // Compares the pre-edge value, so MATCH trails Q==CMP by one cycle.
   always_ff @(posedge CP or posedge MR) begin
      if (MR)
         match_r <= 1'b0;
      else
         match_r <= (q_r == bus.CMP);
   end

   assign bus.MATCH = match_r;
`endif
endmodule

// File: tb/tb_hct_counter_n.sv
// tb/tb_hct_counter_n.sv - directed self-checking bench for hct_counter_n.
module tb_hct_counter_n;
   logic CP = 1'b0;
   logic MR;
   int   tests_run = 0;
   int   tests_failed = 0;

   hct_counter_n_if #(.WIDTH(4)) b0 ();
   hct_counter_n_if #(.WIDTH(4)) bs ();
   hct_counter_n_if #(.WIDTH(4)) bl ();
   hct_counter_n_if #(.WIDTH(4)) bh ();

   hct_counter_n #(.WIDTH(4), .SATURATE(0)) u_wrap (.CP(CP), .MR(MR), .bus(b0));
   hct_counter_n #(.WIDTH(4), .SATURATE(1)) u_sat  (.CP(CP), .MR(MR), .bus(bs));
   hct_counter_n #(.WIDTH(4), .SATURATE(0)) u_lo   (.CP(CP), .MR(MR), .bus(bl));
   hct_counter_n #(.WIDTH(4), .SATURATE(0)) u_hi   (.CP(CP), .MR(MR), .bus(bh));

   assign bh.CET = bl.TC;
   assign bh.CEP = bl.CEP;

   always #5 CP = ~CP;

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      MR = 1'b1;
      b0._SR = 1'b1; b0._PE = 1'b1; b0.CEP = 1'b0; b0.CET = 1'b1; b0.UP = 1'b0;
      b0.LIMIT = 4'hF; b0.D = 4'h0;
      bs._SR = 1'b1; bs._PE = 1'b1; bs.CEP = 1'b0; bs.CET = 1'b1; bs.UP = 1'b0;
      bs.LIMIT = 4'hF; bs.D = 4'h0;
      bl._SR = 1'b1; bl._PE = 1'b1; bl.CEP = 1'b0; bl.CET = 1'b1; bl.UP = 1'b1;
      bl.LIMIT = 4'hF; bl.D = 4'h0;
      bh._SR = 1'b1; bh._PE = 1'b1; bh.UP = 1'b1; bh.LIMIT = 4'hF; bh.D = 4'h0;
`ifdef HCT_COUNTER_MATCH_EN
      b0.CMP = 4'd7; bs.CMP = 4'd0; bl.CMP = 4'd0; bh.CMP = 4'd0;
`endif
      #1;
      check("reset_q", int'(b0.Q), 0);
      check("reset_tc_down", int'(b0.TC), 1);
      #11;
      MR = 1'b0;

      // Asynchronous reset from Q=9
      b0._PE = 1'b0; b0.D = 4'd9;
      step();
      check("load9", int'(b0.Q), 9);
      b0._PE = 1'b1;
      #2 MR = 1'b1;
      #1 check("async_mr", int'(b0.Q), 0);
      MR = 1'b0;

      // Full 4-bit count
      b0.CEP = 1'b1; b0.CET = 1'b1; b0.UP = 1'b1; b0.LIMIT = 4'hF;
      for (int i = 0; i < 16; i++) begin
         step();
         check("bin_q", int'(b0.Q), (i + 1) % 16);
         check("bin_tc", int'(b0.TC), int'(((i + 1) % 16) == 15));
      end

      // Modulus 10
      b0.LIMIT = 4'd9;
      for (int i = 0; i < 20; i++) begin
         step();
         check("mod_q", int'(b0.Q), (i + 1) % 10);
         check("mod_tc", int'(b0.TC), int'(((i + 1) % 10) == 9));
      end
      for (int i = 0; i < 9; i++) step();
      check("mod_at9", int'(b0.Q), 9);
      b0.CET = 1'b0;
      #1 check("cet_gates_tc", int'(b0.TC), 0);
      step();
      check("cet_hold", int'(b0.Q), 9);
      b0.CET = 1'b1;

      // Priority: clear beats load beats count
      b0._PE = 1'b0; b0.D = 4'd6;
      step();
      check("load6", int'(b0.Q), 6);
      b0._SR = 1'b0; b0.D = 4'd12;
      step();
      check("sr_over_pe", int'(b0.Q), 0);
      b0._SR = 1'b1;
      step();
      check("pe_load12", int'(b0.Q), 12);
      b0._PE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("above_limit_q", int'(b0.Q), (13 + i) % 16);
         check("above_limit_tc", int'(b0.TC), 0);
      end

      // LIMIT=0 corner
      b0.LIMIT = 4'd0;
      step();
      check("lim0_up_q", int'(b0.Q), 0);
      check("lim0_up_tc", int'(b0.TC), 1);
      b0.UP = 1'b0;
      step();
      check("lim0_down_q", int'(b0.Q), 0);

      // Down count with reload
      b0.LIMIT = 4'd9; b0._PE = 1'b0; b0.D = 4'd2;
      step();
      b0._PE = 1'b1;
      step();
      check("down_1", int'(b0.Q), 1);
      step();
      check("down_0", int'(b0.Q), 0);
      check("down_tc0", int'(b0.TC), 1);
      step();
      check("down_reload", int'(b0.Q), 9);
      b0.CEP = 1'b0;

      // Saturating instance
      bs._PE = 1'b0; bs.D = 4'd3; bs.UP = 1'b0;
      step();
      check("sat_load3", int'(bs.Q), 3);
      check("sat_tc_at3", int'(bs.TC), 0);
      bs._PE = 1'b1; bs.CEP = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("sat_down_q", int'(bs.Q), (i < 3) ? 2 - i : 0);
         check("sat_down_tc", int'(bs.TC), int'(i >= 2));
      end
      bs.UP = 1'b1; bs.LIMIT = 4'd5;
      for (int i = 0; i < 7; i++) begin
         step();
         check("sat_up_q", int'(bs.Q), (i < 5) ? i + 1 : 5);
         check("sat_up_tc", int'(bs.TC), int'(i >= 4));
      end
      bs.CEP = 1'b0;

      // Cascade
      bl._PE = 1'b0; bh._PE = 1'b0; bl.D = 4'hE; bh.D = 4'h0;
      step();
      bl._PE = 1'b1; bh._PE = 1'b1; bl.CEP = 1'b1;
      step();
      check("casc_0f", int'({bh.Q, bl.Q}), 8'h0F);
      step();
      check("casc_10", int'({bh.Q, bl.Q}), 8'h10);
      bl._PE = 1'b0; bh._PE = 1'b0; bl.D = 4'hE; bh.D = 4'hF;
      step();
      bl._PE = 1'b1; bh._PE = 1'b1;
      step();
      check("casc_ff", int'({bh.Q, bl.Q}), 8'hFF);
      check("casc_tcs", int'({bh.TC, bl.TC}), 3);
      step();
      check("casc_00", int'({bh.Q, bl.Q}), 8'h00);
      bl.CEP = 1'b0;

`ifdef HCT_COUNTER_MATCH_EN
      b0._SR = 1'b0; b0.UP = 1'b1; b0.LIMIT = 4'hF; b0.CEP = 1'b1;
      step();
      b0._SR = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("match", int'(b0.MATCH), int'(i == 8));
      end
      #2 MR = 1'b1;
      #1 check("match_mr", int'(b0.MATCH), 0);
      MR = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
